bus_err_collector: RTL and testbench
====================================

Name: bus_err_collector

Overview:
Drains the error FIFO of a bus error unit: pops each pending error record, updates per-error-code statistics and the first/last error snapshots, and forwards every record on a ready/valid log stream. It sits between the bus error unit's pop/readout interface and a register file or trace sink. It produces a summarized interrupt from sticky status and a programmable count threshold.

Parameters:
AddrWidth, 48, error address width (matches the error unit)
MetaDataWidth, 1, metadata width
ErrBits, 3, error code width; 2^ErrBits per-code counters
CntWidth, 16, width of every statistics counter (saturating)
HaltOnOverflow, 1'b0, enter HALT when source FIFO overflow is seen

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
en_i  in  1  collection enable
clr_i  in  1  clear all statistics, snapshots and sticky flags; release HALT
thresh_i  in  CntWidth  interrupt threshold on the total count; 0 disables
err_irq_i  in  1  source FIFO non-empty; head record valid
err_code_i  in  ErrBits  head error code
err_addr_i  in  AddrWidth  head address
err_meta_i  in  MetaDataWidth  head metadata
err_fifo_overflow_i  in  1  source FIFO full
err_fifo_pop_o  out  1  pop the source FIFO head
log_valid_o  out  1  log record valid
log_ready_i  in  1  log sink ready
log_code_o / log_addr_o / log_meta_o  out  ErrBits / AddrWidth / MetaDataWidth  log record
cnt_o  out  2^ErrBits x CntWidth  per-code error counts
total_o  out  CntWidth  total popped errors
first_valid_o  out  1  first-error snapshot valid
first_code_o / first_addr_o / first_meta_o  out  per field  first error since clear
last_code_o / last_addr_o / last_meta_o  out  per field  most recent error
overflow_o  out  1  sticky source overflow
halted_o  out  1  FSM in HALT
irq_o  out  1  summary interrupt

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters, snapshots and stickies 0.
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- FSM states:
  - IDLE -> DRAIN when en_i & err_irq_i & ~clr_i.
  - DRAIN -> IDLE when ~en_i or ~err_irq_i.
  - HALT is entered from any state when HaltOnOverflow and overflow_o are both set.
  - HALT -> IDLE only on clr_i.
- Pop condition: err_fifo_pop_o = (state==DRAIN) & err_irq_i & en_i & ~clr_i & (~log_valid_o | log_ready_i).
  - Combinational from inputs and state.
  - Never asserted in IDLE or HALT.
  - Back-to-back pops are allowed, one per cycle.
- Pop at cycle t: the following take effect at t+1 (1-cycle latency):
  - head record loaded into the log register; log_valid_o=1.
  - cnt_o[code] and total_o increment, saturating at all-ones.
  - last_* snapshot updated.
  - first_* captured only if first_valid_o=0; first_valid_o then set.
- Log stream: log_valid_o and the record are held stable until log_ready_i.
  - Beat accepted with no new pop: log_valid_o falls next cycle.
  - Accept and pop in the same cycle: the new record replaces the old with no bubble.
- overflow_o sets on any cycle with err_fifo_overflow_i=1; it is cleared only by clr_i or reset.
  - If overflow_i and clr_i coincide, clear wins.
- clr_i:
  - Zeroes counters, snapshots, first_valid_o and overflow_o.
  - FSM -> IDLE.
  - Blocks the pop in the same cycle; an entry pending at that time is popped on a later cycle and counted post-clear.
  - Does not drop a record already in the log register.
- irq_o = first_valid_o | overflow_o | (thresh_i!=0 & total_o>=thresh_i). Registered-output based, so it follows those outputs with no extra delay.
- Code 0 is counted like any other code (no special case).
- en_i low mid-DRAIN: no further pops; the log register still drains.

Decomposition:
- Package bus_err_collector_pkg holds:
  - FSM state enum (IDLE, DRAIN, HALT).
  - Saturating increment function, parameterized by width via a localparam-free mask argument.
- The record struct is a local typedef (parameter-dependent).
- Sub-module bus_err_sat_cnt: saturating counter with inc and clr; instantiated 2^ErrBits+1 times.

Test Plan:
1. Burst drain: 3 records, code 1, addr 0x1000/0x2000/0x3000, log_ready_i=1.
   -> pops on 3 consecutive cycles; cnt_o[1]=3, total_o=3; first_addr_o=0x1000, last_addr_o=0x3000; 3 log beats.
2. Backpressure: 2 records, log_ready_i=0.
   -> exactly 1 pop; log_valid_o held with addr of record 1.
   -> ready=1 for one cycle: second pop in that cycle; log shows record 2 next cycle.
3. Saturation, CntWidth=4: 20 errors of code 2.
   -> cnt_o[2]=15, total_o=15; no wrap.
4. Halt: HaltOnOverflow=1, err_fifo_overflow_i pulsed with entries pending.
   -> overflow_o=1, halted_o=1, irq_o=1, no pops.
   -> clr_i: IDLE, counters 0; drain resumes.
5. Clear collision: clr_i while err_irq_i=1 and cnt_o[3]=5.
   -> no pop that cycle; next pop yields cnt_o[3]=1, first_valid_o=1.
6. Threshold: thresh_i=2, two errors.
   -> irq_o rises with the first (first_valid_o); after clr_i with thresh_i=2, irq_o rises again at the first pop via first_valid_o, and remains asserted after the second.

Source files
------------

// File: rtl/bus_err_collector_pkg.sv
// bus_err_collector_pkg: drain FSM states and the saturating-increment helper.
package bus_err_collector_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, HALT} state_e;

    // Values never exceed mask, so mask is the saturation point.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] mask);
        return (v == mask) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/bus_err_sat_cnt.sv
// bus_err_sat_cnt: statistics counter that sticks at all-ones instead of wrapping.
module bus_err_sat_cnt
    import bus_err_collector_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) r_cnt <= '0;
        else if (inc_i) r_cnt <= Width'(sat_inc(64'(r_cnt), 64'({Width{1'b1}})));
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/bus_err_collector.sv
// bus_err_collector: drains the bus error FIFO into per-code statistics, first/last
// snapshots and a ready/valid log stream, with a summary interrupt.
module bus_err_collector
    import bus_err_collector_pkg::*;
#(
    parameter int   AddrWidth      = 48,
    parameter int   MetaDataWidth  = 1,
    parameter int   ErrBits        = 3,
    parameter int   CntWidth       = 16,
    parameter logic HaltOnOverflow = 1'b0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  en_i,
    input  logic                                  clr_i,
    input  logic [CntWidth-1:0]                   thresh_i,
    input  logic                                  err_irq_i,
    input  logic [ErrBits-1:0]                    err_code_i,
    input  logic [AddrWidth-1:0]                  err_addr_i,
    input  logic [MetaDataWidth-1:0]              err_meta_i,
    input  logic                                  err_fifo_overflow_i,
    output logic                                  err_fifo_pop_o,
    output logic                                  log_valid_o,
    input  logic                                  log_ready_i,
    output logic [ErrBits-1:0]                    log_code_o,
    output logic [AddrWidth-1:0]                  log_addr_o,
    output logic [MetaDataWidth-1:0]              log_meta_o,
    output logic [2**ErrBits-1:0][CntWidth-1:0]   cnt_o,
    output logic [CntWidth-1:0]                   total_o,
    output logic                                  first_valid_o,
    output logic [ErrBits-1:0]                    first_code_o,
    output logic [AddrWidth-1:0]                  first_addr_o,
    output logic [MetaDataWidth-1:0]              first_meta_o,
    output logic [ErrBits-1:0]                    last_code_o,
    output logic [AddrWidth-1:0]                  last_addr_o,
    output logic [MetaDataWidth-1:0]              last_meta_o,
    output logic                                  overflow_o,
    output logic                                  halted_o,
    output logic                                  irq_o
);

    localparam int NumCodes = 2 ** ErrBits;

    typedef struct packed {
        logic [ErrBits-1:0]       code;
        logic [AddrWidth-1:0]     addr;
        logic [MetaDataWidth-1:0] meta;
    } rec_t;

    state_e r_state, w_state_nxt;
    rec_t   w_head, r_log, r_first, r_last;
    logic   r_log_valid, r_first_valid, r_overflow, w_pop;

    assign w_head = '{code: err_code_i, addr: err_addr_i, meta: err_meta_i};
    // Pop only when the log register is free or being emptied this cycle.
    assign w_pop  = (r_state == DRAIN) && err_irq_i && en_i && !clr_i && (!r_log_valid || log_ready_i);

    always_comb begin
        w_state_nxt = r_state;
        if (clr_i) w_state_nxt = IDLE;
        else if (HaltOnOverflow && r_overflow) w_state_nxt = HALT;
        else if (r_state == IDLE && en_i && err_irq_i) w_state_nxt = DRAIN;
        else if (r_state == DRAIN && !(en_i && err_irq_i)) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_log_valid <= 1'b0;
            r_log       <= '0;
        end else if (w_pop) begin
            r_log_valid <= 1'b1;
            r_log       <= w_head;
        end else if (log_ready_i) begin
            r_log_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_first_valid <= 1'b0;
            r_first       <= '0;
            r_last        <= '0;
        end else if (w_pop) begin
            r_last <= w_head;
            if (!r_first_valid) begin
                r_first       <= w_head;
                r_first_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) r_overflow <= 1'b0;
        else if (err_fifo_overflow_i) r_overflow <= 1'b1;
    end

    for (genvar i = 0; i < NumCodes; i++) begin : g_cnt
        bus_err_sat_cnt #(.Width(CntWidth)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clr_i),
            .inc_i (w_pop && err_code_i == ErrBits'(i)),
            .cnt_o (cnt_o[i])
        );
    end

    bus_err_sat_cnt #(.Width(CntWidth)) u_total (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (w_pop),
        .cnt_o (total_o)
    );

    assign err_fifo_pop_o = w_pop;
    assign log_valid_o    = r_log_valid;
    assign log_code_o     = r_log.code;
    assign log_addr_o     = r_log.addr;
    assign log_meta_o     = r_log.meta;
    assign first_valid_o  = r_first_valid;
    assign first_code_o   = r_first.code;
    assign first_addr_o   = r_first.addr;
    assign first_meta_o   = r_first.meta;
    assign last_code_o    = r_last.code;
    assign last_addr_o    = r_last.addr;
    assign last_meta_o    = r_last.meta;
    assign overflow_o     = r_overflow;
    assign halted_o       = (r_state == HALT);
    assign irq_o          = r_first_valid | r_overflow | (thresh_i != '0 && total_o >= thresh_i);

endmodule

// File: tb/tb_bus_err_collector.sv
// tb_bus_err_collector: source-FIFO model, scoreboarded log stream and a reference model
// of the statistics, snapshots, sticky overflow and halt for bus_err_collector.
module tb_bus_err_collector;

    localparam int AW = 48, MW = 1, EB = 3, CW = 4, NC = 8, CMAX = 15;

    typedef struct packed {
        logic [EB-1:0] code;
        logic [AW-1:0] addr;
        logic [MW-1:0] meta;
    } rec_t;

    logic                  clk_i = 1'b0;
    logic                  rst_i, en_i, clr_i, err_irq_i, err_fifo_overflow_i, log_ready_i;
    logic [CW-1:0]         thresh_i;
    logic [EB-1:0]         err_code_i;
    logic [AW-1:0]         err_addr_i;
    logic [MW-1:0]         err_meta_i;
    logic                  err_fifo_pop_o, log_valid_o, first_valid_o, overflow_o, halted_o, irq_o;
    logic [EB-1:0]         log_code_o, first_code_o, last_code_o;
    logic [AW-1:0]         log_addr_o, first_addr_o, last_addr_o;
    logic [MW-1:0]         log_meta_o, first_meta_o, last_meta_o;
    logic [NC-1:0][CW-1:0] cnt_o;
    logic [CW-1:0]         total_o;

    always #5 clk_i = ~clk_i;

    bus_err_collector #(
        .AddrWidth(AW), .MetaDataWidth(MW), .ErrBits(EB), .CntWidth(CW), .HaltOnOverflow(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .thresh_i(thresh_i),
        .err_irq_i(err_irq_i), .err_code_i(err_code_i), .err_addr_i(err_addr_i),
        .err_meta_i(err_meta_i), .err_fifo_overflow_i(err_fifo_overflow_i),
        .err_fifo_pop_o(err_fifo_pop_o), .log_valid_o(log_valid_o), .log_ready_i(log_ready_i),
        .log_code_o(log_code_o), .log_addr_o(log_addr_o), .log_meta_o(log_meta_o),
        .cnt_o(cnt_o), .total_o(total_o), .first_valid_o(first_valid_o),
        .first_code_o(first_code_o), .first_addr_o(first_addr_o), .first_meta_o(first_meta_o),
        .last_code_o(last_code_o), .last_addr_o(last_addr_o), .last_meta_o(last_meta_o),
        .overflow_o(overflow_o), .halted_o(halted_o), .irq_o(irq_o)
    );

    rec_t src_q[$];
    rec_t exp_q[$];
    int   pop_cyc[$];
    int   n_chk = 0, n_pass = 0, n_pop = 0, n_beat = 0, cyc = 0;

    int   m_cnt[NC];
    int   m_total;
    logic m_fv, m_ovf, m_halt, m_lv, m_hold, m_on = 1'b0;
    rec_t m_first, m_last, m_held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Source FIFO: head is presented shortly after each edge.
    always begin
        @(posedge clk_i);
        #2;
        err_irq_i = src_q.size() != 0;
        if (src_q.size() != 0) {err_code_i, err_addr_i, err_meta_i} = src_q[0];
    end

    // Monitor: compare against the model, then advance the model by this cycle's inputs.
    always @(negedge clk_i) begin
        rec_t rec;
        logic got;
        got = 1'b0;
        if (rst_i) begin
            m_on = 1'b1; m_total = 0; m_fv = 0; m_ovf = 0; m_halt = 0; m_lv = 0; m_hold = 0;
            m_first = '0; m_last = '0;
            for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        end else if (m_on) begin
            cyc++;
            for (int i = 0; i < NC; i++) chk($sformatf("cnt[%0d]", i), 64'(cnt_o[i]), 64'(m_cnt[i]));
            chk("total", 64'(total_o), 64'(m_total));
            chk("first_valid", 64'(first_valid_o), 64'(m_fv));
            chk("first_rec", 64'({first_code_o, first_addr_o, first_meta_o}), 64'(m_first));
            chk("last_rec", 64'({last_code_o, last_addr_o, last_meta_o}), 64'(m_last));
            chk("overflow", 64'(overflow_o), 64'(m_ovf));
            chk("halted", 64'(halted_o), 64'(m_halt));
            chk("irq", 64'(irq_o), 64'(m_fv || m_ovf || (thresh_i != 0 && m_total >= int'(thresh_i))));
            chk("log_valid", 64'(log_valid_o), 64'(m_lv));
            if (m_hold) chk("log_hold", 64'({log_code_o, log_addr_o, log_meta_o}), 64'(m_held));
            if (log_valid_o && log_ready_i) begin
                n_beat++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL log_extra: got beat addr 0x%0h, expected no beat", log_addr_o);
                end else chk("log_rec", 64'({log_code_o, log_addr_o, log_meta_o}), 64'(exp_q.pop_front()));
            end
            m_hold = log_valid_o && !log_ready_i;
            m_held = {log_code_o, log_addr_o, log_meta_o};
            if (err_fifo_pop_o) begin
                n_pop++;
                pop_cyc.push_back(cyc);
                chk("pop_legal", 64'(src_q.size() != 0 && en_i && !clr_i && !m_halt && (!m_lv || log_ready_i)), 64'd1);
                if (src_q.size() != 0) begin
                    rec = src_q.pop_front();
                    got = 1'b1;
                end
            end
            if (clr_i) begin
                m_total = 0; m_fv = 0; m_ovf = 0; m_halt = 0; m_first = '0; m_last = '0;
                for (int i = 0; i < NC; i++) m_cnt[i] = 0;
            end else begin
                m_halt = m_halt || m_ovf;
                if (err_fifo_overflow_i) m_ovf = 1'b1;
                if (got) begin
                    m_cnt[rec.code] = (m_cnt[rec.code] < CMAX) ? m_cnt[rec.code] + 1 : CMAX;
                    m_total = (m_total < CMAX) ? m_total + 1 : CMAX;
                    m_last = rec;
                    if (!m_fv) begin
                        m_first = rec;
                        m_fv = 1'b1;
                    end
                end
            end
            m_lv = err_fifo_pop_o || (m_lv && !log_ready_i);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [EB-1:0] c, input logic [AW-1:0] a);
        rec_t r;
        r.code = c;
        r.addr = a;
        r.meta = MW'($urandom);
        src_q.push_back(r);
        exp_q.push_back(r);
    endtask

    task automatic clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    initial begin
        int p0, b0, budget;
        rst_i = 1; en_i = 0; clr_i = 0; thresh_i = '0; log_ready_i = 1; err_fifo_overflow_i = 0;
        err_irq_i = 0; err_code_i = '0; err_addr_i = '0; err_meta_i = '0;
        tick(3);
        rst_i = 0;
        chk("rst_total", 64'(total_o), 64'd0);
        chk("rst_log_valid", 64'(log_valid_o), 64'd0);
        chk("rst_pop", 64'(err_fifo_pop_o), 64'd0);
        chk("rst_irq", 64'(irq_o), 64'd0);
        chk("rst_halted", 64'(halted_o), 64'd0);
        chk("rst_first_valid", 64'(first_valid_o), 64'd0);

        // Burst drain
        en_i = 1; p0 = n_pop; b0 = n_beat;
        push(3'd1, 48'h1000); push(3'd1, 48'h2000); push(3'd1, 48'h3000);
        tick(8);
        chk("burst_cnt1", 64'(cnt_o[1]), 64'd3);
        chk("burst_total", 64'(total_o), 64'd3);
        chk("burst_first_addr", 64'(first_addr_o), 64'h1000);
        chk("burst_last_addr", 64'(last_addr_o), 64'h3000);
        chk("burst_beats", 64'(n_beat - b0), 64'd3);
        chk("burst_pops", 64'(n_pop - p0), 64'd3);
        if (pop_cyc.size() >= 3) chk("burst_consec", 64'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-3]), 64'd2);
        clear();

        // Backpressure
        log_ready_i = 0; p0 = n_pop;
        push(3'd4, 48'hA); push(3'd4, 48'hB);
        tick(6);
        chk("bp_one_pop", 64'(n_pop - p0), 64'd1);
        chk("bp_valid", 64'(log_valid_o), 64'd1);
        chk("bp_addr", 64'(log_addr_o), 64'hA);
        log_ready_i = 1;
        #2 chk("bp_pop_on_ready", 64'(err_fifo_pop_o), 64'd1);
        tick();
        log_ready_i = 0;
        chk("bp_addr2", 64'(log_addr_o), 64'hB);
        chk("bp_valid2", 64'(log_valid_o), 64'd1);
        log_ready_i = 1;
        tick(3);
        clear();

        // Saturation
        p0 = n_pop;
        for (int i = 0; i < 20; i++) push(3'd2, AW'($urandom));
        tick(30);
        chk("sat_cnt2", 64'(cnt_o[2]), 64'd15);
        chk("sat_total", 64'(total_o), 64'd15);
        chk("sat_pops", 64'(n_pop - p0), 64'd20);
        clear();

        // Halt on overflow
        en_i = 0; p0 = n_pop;
        push(3'd5, 48'h50); push(3'd5, 48'h51);
        err_fifo_overflow_i = 1;
        tick();
        err_fifo_overflow_i = 0; en_i = 1;
        tick(5);
        chk("halt_ovf", 64'(overflow_o), 64'd1);
        chk("halt_halted", 64'(halted_o), 64'd1);
        chk("halt_irq", 64'(irq_o), 64'd1);
        chk("halt_no_pop", 64'(n_pop - p0), 64'd0);
        clear();
        chk("halt_release", 64'(halted_o), 64'd0);
        chk("halt_ovf_clr", 64'(overflow_o), 64'd0);
        tick(6);
        chk("halt_resume_total", 64'(total_o), 64'd2);
        chk("halt_resume_cnt5", 64'(cnt_o[5]), 64'd2);

        // Clear collides with a pending entry
        clear();
        for (int i = 0; i < 4; i++) push(3'd3, AW'($urandom));
        tick(8);
        log_ready_i = 0;
        push(3'd3, 48'hC0); push(3'd3, 48'hC1);
        tick(6);
        chk("clr_pre_cnt3", 64'(cnt_o[3]), 64'd5);
        clr_i = 1; log_ready_i = 1;
        #2 chk("clr_blocks_pop", 64'(err_fifo_pop_o), 64'd0);
        tick();
        clr_i = 0;
        chk("clr_cnt3_zero", 64'(cnt_o[3]), 64'd0);
        tick(4);
        chk("clr_post_cnt3", 64'(cnt_o[3]), 64'd1);
        chk("clr_post_first_valid", 64'(first_valid_o), 64'd1);
        chk("clr_post_first_addr", 64'(first_addr_o), 64'hC1);

        // Threshold
        clear();
        thresh_i = 4'd2;
        push(3'd6, 48'h60);
        tick(5);
        chk("th_irq1", 64'(irq_o), 64'd1);
        push(3'd6, 48'h61);
        tick(5);
        chk("th_total2", 64'(total_o), 64'd2);
        chk("th_irq2", 64'(irq_o), 64'd1);
        clear();
        chk("th_irq_clr", 64'(irq_o), 64'd0);
        push(3'd0, 48'h70);
        tick(5);
        chk("th_irq_again", 64'(irq_o), 64'd1);
        chk("th_code0_cnt", 64'(cnt_o[0]), 64'd1);
        push(3'd0, 48'h71);
        tick(5);
        chk("th_irq_hold", 64'(irq_o), 64'd1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            en_i = $urandom_range(0, 9) != 0;
            log_ready_i = $urandom_range(0, 9) < 7;
            clr_i = $urandom_range(0, 49) == 0;
            err_fifo_overflow_i = $urandom_range(0, 99) == 0;
            thresh_i = CW'($urandom_range(0, 8));
            if (src_q.size() < 8 && $urandom_range(0, 1) == 1) push(EB'($urandom), AW'({$urandom, $urandom}));
            tick();
        end
        err_fifo_overflow_i = 0; en_i = 1; log_ready_i = 1;
        clear();
        budget = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || log_valid_o) && budget < 200) begin
            tick();
            budget++;
        end
        chk("drain_src_empty", 64'(src_q.size()), 64'd0);
        chk("drain_log_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
